// File: rtl/regfile_sb.sv
// regfile_sb: 2-read / 1-write register file with a per-register busy
// scoreboard for in-flight long-latency results.
// r0 is hardwired to zero and can never be busy.
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write data
// to a matching read port and mask that port's hazard contribution.
module regfile_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              lock_en,
  input  logic [ADDR_W-1:0] lock_addr,
  output logic              hazard
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;
  logic              wr_ok;
  logic              lock_ok;
  logic              rs_haz;
  logic              rt_haz;

  assign wr_ok   = wr_en   && (wr_addr   != '0);
  assign lock_ok = lock_en && (lock_addr != '0);

  // Busy next-state: clear on writeback first, then set on lock so a
  // same-address lock overrides the clear.
  always_comb begin
    busy_d = busy_q;
    if (wr_ok) begin
      busy_d[wr_addr] = 1'b0;
    end
    if (lock_ok) begin
      busy_d[lock_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Busy register with synchronous reset taking priority over lock/clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Register storage; writes to r0 are dropped, reset zeroes every entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_ok) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  // Combinational read ports with r0 forced to zero.
  always_comb begin
    rs_data = (rs_addr == '0) ? '0 : regs_q[rs_addr];
    rt_data = (rt_addr == '0) ? '0 : regs_q[rt_addr];
`ifdef REGFILE_BYPASS_EN
    if (wr_ok && (rs_addr == wr_addr)) begin
      rs_data = wr_data;
    end
    if (wr_ok && (rt_addr == wr_addr)) begin
      rt_data = wr_data;
    end
`endif
  end

  // Hazard: either read address names a busy register (busy_q[0] is always 0).
  always_comb begin
    rs_haz = busy_q[rs_addr];
    rt_haz = busy_q[rt_addr];
`ifdef REGFILE_BYPASS_EN
    if (wr_ok && (rs_addr == wr_addr)) begin
      rs_haz = 1'b0;
    end
    if (wr_ok && (rt_addr == wr_addr)) begin
      rt_haz = 1'b0;
    end
`endif
    hazard = rs_haz | rt_haz;
  end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter DATA_W, default 32, register and data width in bits.
REQ-002 Parameter ADDR_W, default 5, register address width; depth is 2**ADDR_W (32).
REQ-003 clk  input  1  rising-edge clock; sole clock.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 rs_addr  input  ADDR_W  read port A address.
REQ-006 rt_addr  input  ADDR_W  read port B address.
REQ-007 rs_data  output  DATA_W  read port A data.
REQ-008 rt_data  output  DATA_W  read port B data.
REQ-009 wr_en  input  1  write enable, writeback stage.
REQ-010 wr_addr  input  ADDR_W  write address, from the 5-bit destination-select mux.
REQ-011 wr_data  input  DATA_W  write data, from the 32-bit writeback-select mux.
REQ-012 lock_en  input  1  marks lock_addr busy when a long-latency (load) result is in flight.
REQ-013 lock_addr  input  ADDR_W  destination register being locked.
REQ-014 hazard  output  1  high when either read address refers to a busy register.

Function
REQ-015 Reads SHALL be combinational: rs_data = reg[rs_addr], rt_data = reg[rt_addr], with zero clock latency.
REQ-016 Address 0 SHALL read as 0 on both ports regardless of any write.
REQ-017 When wr_en=1 and wr_addr!=0, reg[wr_addr] SHALL take wr_data at the next rising clk edge; writes to address 0 are discarded.
REQ-018 Each register SHALL have a busy bit; busy[0] is constant 0.
REQ-019 When lock_en=1 and lock_addr!=0, busy[lock_addr] SHALL be set at the rising edge.
REQ-020 When wr_en=1 and wr_addr!=0, busy[wr_addr] SHALL be cleared at the rising edge.
REQ-021 If set and clear target the same address on the same edge, set SHALL win and the bit ends at 1.
REQ-022 Set and clear on different addresses in one cycle SHALL both take effect.
REQ-023 hazard SHALL be combinational: busy[rs_addr] OR busy[rt_addr]; an address of 0 never contributes.
REQ-024 Locking an address that is already busy SHALL leave it busy, with no error indication.
REQ-025 Clearing an address that is not busy SHALL leave it clear.

Reset
REQ-026 When reset=1 at a rising edge, all registers and all busy bits SHALL become 0.
REQ-027 Reset SHALL take priority over wr_en and lock_en in the same cycle; pending writes and locks are dropped.
REQ-028 After reset: rs_data=0, rt_data=0, hazard=0 for every address.
REQ-029 Reset asserted mid-operation with busy bits set SHALL clear them within that single edge.

Configuration
REQ-030 Macro REGFILE_BYPASS_EN selects write-to-read bypass.
- Defined: when wr_en=1, wr_addr!=0 and a read address equals wr_addr, that port SHALL return wr_data in the same cycle, and that port's hazard contribution SHALL be masked.
- Not defined: a same-cycle read SHALL return the old register value and hazard follows REQ-023; the new value is visible from the next cycle.

Verification
REQ-031 Reset, then read all 32 addresses on both ports -> every read is 0 and hazard=0.
REQ-032 Write 0xDEADBEEF to r8, then read r8 on rs and r0 on rt next cycle -> rs_data=0xDEADBEEF, rt_data=0. Write 0x12345678 to r0 -> r0 still reads 0.
REQ-033 Lock r5, then set rs_addr=5 -> hazard=1. Write r5=0x55 -> hazard=0 the next cycle and rs_data=0x55.
REQ-034 Set lock_en with lock_addr=9 and wr_en with wr_addr=9 in the same cycle -> busy[9]=1, hazard=1 on reading r9, and r9 holds wr_data.
REQ-035 Write r3=0xA5A5A5A5 with rs_addr=3 in the same cycle -> rs_data=0xA5A5A5A5 with REGFILE_BYPASS_EN defined, old value without it.
REQ-036 Lock r4 and write r7=0x77, then assert reset together with wr_en (r2=0x22) -> next cycle r2=0, r7=0, and hazard=0 for r4.
